// File: rtl/savestates_restore_seq.sv
// Savestate restore sequencer: streams bytes back into PPU ($21xx), CPU I/O ($42xx) and,
// with SS_WRAM_RESTORE_EN defined, WRAM port ($2181-$2183). The write data port is named
// dout because "do" is a reserved word.
module savestates_restore_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       wr_slot_ce,
    output logic       rd_req,
    input  logic       rd_ack,
    input  logic [7:0] rd_di,
    output logic [7:0] pa,
    output logic       pawr_ce,
    output logic [7:0] io_a,
    output logic       iowr_ce,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] PH_PPU  = 2'd0;
    localparam logic [1:0] PH_IO   = 2'd1;
`ifdef SS_WRAM_RESTORE_EN
    localparam logic [1:0] PH_WRAM = 2'd2;
    localparam logic [6:0] TOTAL_BYTES = 7'd79;
`else
    localparam logic [6:0] TOTAL_BYTES = 7'd76;
`endif

    logic [2:0] state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] idx_q, idx_d;
    logic       hi_q, hi_d;
    logic       cg_flag_q, cg_flag_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] data_q, data_d;

    logic       is_word;
    logic       is_cg_byte;
    logic       is_io;
    logic       want_write;
    logic       write_done;
    logic       last_byte;
    logic [7:0] wr_pa;

    // IO registers in restore order; NMITIMEN goes last so NMIs stay off until the end.
    function automatic logic [7:0] io_addr(input logic [7:0] idx);
        logic [7:0] a;
        case (idx)
            8'd0:    a = 8'h02;
            8'd1:    a = 8'h03;
            8'd2:    a = 8'h04;
            8'd3:    a = 8'h05;
            8'd4:    a = 8'h06;
            8'd5:    a = 8'h07;
            8'd6:    a = 8'h08;
            8'd7:    a = 8'h09;
            8'd8:    a = 8'h0A;
            8'd9:    a = 8'h0C;
            8'd10:   a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign is_word = (phase_q == PH_PPU) &&
                     (((idx_q >= 8'h0D) && (idx_q <= 8'h14)) ||
                      ((idx_q >= 8'h1B) && (idx_q <= 8'h20)));
    assign is_cg_byte = (phase_q == PH_PPU) && (idx_q == 8'h21) && hi_q;
    assign is_io      = (phase_q == PH_IO);
    assign last_byte  = (byte_cnt_q == TOTAL_BYTES);

    // The CGRAM flag byte is never written; $22 is only written when the flag is set.
    always_comb begin
        want_write = 1'b1;
        if (is_cg_byte) begin
            want_write = 1'b0;
        end else if ((phase_q == PH_PPU) && (idx_q == 8'h22) && !cg_flag_q) begin
            want_write = 1'b0;
        end
    end

    always_comb begin
        wr_pa = idx_q;
`ifdef SS_WRAM_RESTORE_EN
        if (phase_q == PH_WRAM) begin
            wr_pa = 8'h81 + idx_q;
        end
`endif
    end

    assign write_done = (state_q == S_WRITE) && (!want_write || wr_slot_ce);

    assign rd_req  = (state_q == S_FETCH);
    assign pawr_ce = (state_q == S_WRITE) && want_write && wr_slot_ce && !is_io;
    assign iowr_ce = (state_q == S_WRITE) && want_write && wr_slot_ce && is_io;
    assign pa      = ((state_q == S_WRITE) && want_write && !is_io) ? wr_pa : 8'h00;
    assign io_a    = ((state_q == S_WRITE) && want_write && is_io) ? io_addr(idx_q) : 8'h00;
    assign dout    = ((state_q == S_WRITE) && want_write) ? data_q : 8'h00;
    assign busy    = (state_q == S_FETCH) || (state_q == S_WRITE) || (state_q == S_NEXT);
    assign done    = (state_q == S_FIN);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        cg_flag_d  = cg_flag_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    phase_d    = PH_PPU;
                    idx_d      = 8'h00;
                    hi_d       = 1'b0;
                    cg_flag_d  = 1'b0;
                    byte_cnt_d = 7'd0;
                end
            end
            S_FETCH: begin
                if (rd_ack) begin
                    data_d     = rd_di;
                    byte_cnt_d = byte_cnt_q + 7'd1;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (write_done) begin
                    if (is_cg_byte) begin
                        cg_flag_d = data_q[0];
                    end
                    state_d = last_byte ? S_FIN : S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = S_FETCH;
                case (phase_q)
                    PH_PPU: begin
                        if ((is_word || (idx_q == 8'h21)) && !hi_q) begin
                            hi_d = 1'b1;
                        end else begin
                            hi_d = 1'b0;
                            case (idx_q)
                                8'h03:   idx_d = 8'h05;
                                8'h17:   idx_d = 8'h1A;
                                8'h33: begin
                                    phase_d = PH_IO;
                                    idx_d   = 8'h00;
                                end
                                default: idx_d = idx_q + 8'h01;
                            endcase
                        end
                    end
                    PH_IO: begin
`ifdef SS_WRAM_RESTORE_EN
                        if (idx_q == 8'd11) begin
                            phase_d = PH_WRAM;
                            idx_d   = 8'h00;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
`else
                        idx_d = idx_q + 8'h01;
`endif
                    end
`ifdef SS_WRAM_RESTORE_EN
                    PH_WRAM: idx_d = idx_q + 8'h01;
`endif
                    default: ;
                endcase
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_PPU;
            idx_q      <= 8'h00;
            hi_q       <= 1'b0;
            cg_flag_q  <= 1'b0;
            byte_cnt_q <= 7'd0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            cg_flag_q  <= cg_flag_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_savestates_restore_seq.sv
// Scoreboard bench for savestates_restore_seq: a byte-stream model predicts every strobe,
// a responder serves rd_req with fixed or random latency and the monitor pops per strobe.
module tb_savestates_restore_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       wr_slot_ce;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_di;
    logic [7:0] pa;
    logic       pawr_ce;
    logic [7:0] io_a;
    logic       iowr_ce;
    logic [7:0] dout;
    logic       busy;
    logic       done;

    savestates_restore_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .wr_slot_ce (wr_slot_ce),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_di      (rd_di),
        .pa         (pa),
        .pawr_ce    (pawr_ce),
        .io_a       (io_a),
        .iowr_ce    (iowr_ce),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          consumed = 0;
    int          done_cnt = 0;
    int          last_strobe_cyc = -10;
    int          exp_bytes = 0;
    int          ptr = 0;
    bit          rnd_mode = 1'b0;
    logic [7:0]  stream [0:78];
    logic [16:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: walks the register map and pushes {is_io, addr, data} per write.
    task automatic build_expected();
        logic [7:0] io_list [0:11];
        logic       flag;
        int         p;
        io_list = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h08, 8'h09, 8'h0A, 8'h0C, 8'h0D, 8'h00};
        exp_q.delete();
        p    = 0;
        flag = 1'b0;
        for (int a = 0; a <= 'h33; a++) begin
            if (a == 'h04 || a == 'h18 || a == 'h19) continue;
            if ((a >= 'h0D && a <= 'h14) || (a >= 'h1B && a <= 'h20)) begin
                exp_q.push_back({1'b0, 8'(a), stream[p]});
                exp_q.push_back({1'b0, 8'(a), stream[p+1]});
                p += 2;
            end else if (a == 'h21) begin
                exp_q.push_back({1'b0, 8'(a), stream[p]});
                flag = stream[p+1][0];
                p += 2;
            end else if (a == 'h22) begin
                if (flag) exp_q.push_back({1'b0, 8'(a), stream[p]});
                p += 1;
            end else begin
                exp_q.push_back({1'b0, 8'(a), stream[p]});
                p += 1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({1'b1, io_list[i], stream[p]});
            p += 1;
        end
`ifdef SS_WRAM_RESTORE_EN
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 8'(8'h81 + i), stream[p]});
            p += 1;
        end
`endif
        exp_bytes = p;
    endtask

    always @(posedge clk) cyc++;

    // Stream responder and write-slot generator.
    initial begin
        int wait_cnt;
        int slot_ph;
        rd_ack     = 1'b0;
        rd_di      = 8'h00;
        wr_slot_ce = 1'b0;
        wait_cnt   = -1;
        slot_ph    = 0;
        forever begin
            @(posedge clk);
            #1;
            slot_ph++;
            wr_slot_ce = rnd_mode ? ((slot_ph % 4) == 0) : 1'b1;
            if (rd_ack) begin
                rd_ack = 1'b0;
                ptr++;
            end
            if (!rd_req) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt < 0) wait_cnt = rnd_mode ? int'($urandom_range(0, 5)) : 1;
                if (wait_cnt == 0) begin
                    rd_ack   = 1'b1;
                    rd_di    = (ptr < 79) ? stream[ptr] : 8'h00;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Strobe monitor and scoreboard pop.
    always @(negedge clk) begin
        logic [16:0] got;
        logic [16:0] exp;
        if (rd_req && rd_ack) consumed++;
        if (pawr_ce || iowr_ce) begin
            check_eq("one_strobe", 32'(pawr_ce & iowr_ce), 32'd0);
            check_eq("slot_align", 32'(wr_slot_ce), 32'd1);
            check_eq("strobe_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {iowr_ce, (iowr_ce ? io_a : pa), dout};
                check_eq("strobe", 32'(got), 32'(exp));
            end
            last_strobe_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            check_eq("done_busy_low", 32'(busy), 32'd0);
            check_eq("done_after_last", 32'(cyc - last_strobe_cyc), 32'd1);
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic fill_index_stream();
        for (int i = 0; i < 79; i++) stream[i] = 8'(i);
    endtask

    task automatic run_pass(input bit rnd, input bit start_mid);
        bit done_seen;
        rnd_mode  = rnd;
        build_expected();
        ptr       = 0;
        consumed  = 0;
        done_cnt  = 0;
        done_seen = 1'b0;
        pulse_start();
        if (start_mid) begin
            repeat (40) @(posedge clk);
            #2;
            check_eq("busy_mid", 32'(busy), 32'd1);
            pulse_start();
        end
        for (int i = 0; i < 5000 && !done_seen; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check_eq("done_seen", 32'(done_seen), 32'd1);
        // A start coincident with done must not launch another pass.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_after_done", 32'(busy), 32'd0);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("bytes_consumed", 32'(consumed), 32'(exp_bytes));
        check_eq("done_once", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        fill_index_stream();
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'({rd_req, pawr_ce, iowr_ce, busy, done, pa, io_a, dout}),
                 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Index stream, slot always open, ack one cycle after request.
        run_pass(1'b0, 1'b0);

        // CGRAM flag set: $21=$40 then $22=$7F; extra start while busy is ignored.
        stream[44] = 8'h40;
        stream[45] = 8'h01;
        stream[46] = 8'h7F;
        run_pass(1'b0, 1'b1);

        // CGRAM flag clear: no $22 strobe.
        stream[45] = 8'h00;
        run_pass(1'b0, 1'b0);

        // Sparse write slots and random ack latency.
        fill_index_stream();
        run_pass(1'b1, 1'b0);

        // Reset in the middle of a pass, then a full replay from $00.
        rnd_mode = 1'b0;
        build_expected();
        ptr      = 0;
        consumed = 0;
        pulse_start();
        for (int i = 0; i < 2000 && consumed < 20; i++) @(negedge clk);
        check_eq("pre_reset_bytes", 32'(consumed), 32'd20);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("midpass_rst_outputs",
                 32'({rd_req, pawr_ce, iowr_ce, busy, done, pa, io_a, dout}), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run_pass(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
